univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 43 ++++
 rtl/univ_shift_reg_step.sv | 48 ++++
 rtl/univ_shift_reg.sv | 98 +++++++++
 tb/tb_univ_shift_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: mode encodings, mode enum, FSM states.
// UNIV_SHIFT_REG_ROTATE_EN enables the rotate modes; otherwise ROTL/ROTR act as HOLD.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ASR  = 3'd4;
  localparam logic [2:0] MODE_ROTL = 3'd5;
  localparam logic [2:0] MODE_ROTR = 3'd6;

  typedef enum logic [2:0] {
    M_HOLD = MODE_HOLD,
    M_LOAD = MODE_LOAD,
    M_SHL  = MODE_SHL,
    M_SHR  = MODE_SHR,
    M_ASR  = MODE_ASR,
    M_ROTL = MODE_ROTL,
    M_ROTR = MODE_ROTR
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for modes that take count single-bit steps through the step unit.
  function automatic logic is_step_mode(input logic [2:0] m);
    logic r;
    r = 1'b0;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ASR: r = 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROTL, MODE_ROTR:         r = 1'b1;
`endif
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_step.sv
// Combinational single-step datapath: one shift/rotate step and the displaced bit.
// Rotate paths exist only when UNIV_SHIFT_REG_ROTATE_EN is defined.
module shift_step_unit
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  always_comb begin
    nxt     = data;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        nxt     = {data[WIDTH-2:0], ser_in};
        out_bit = data[WIDTH-1];
      end
      MODE_SHR: begin
        nxt     = {ser_in, data[WIDTH-1:1]};
        out_bit = data[0];
      end
      MODE_ASR: begin
        nxt     = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit = data[0];
      end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROTL: begin
        nxt     = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit = data[WIDTH-1];
      end
      MODE_ROTR: begin
        nxt     = {data[0], data[WIDTH-1:1]};
        out_bit = data[0];
      end
`endif
      default: begin
        nxt     = data;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: start-triggered LOAD/shift/rotate operations run by an IDLE/RUN/DONE FSM.
// Define UNIV_SHIFT_REG_ROTATE_EN to build the ROTL/ROTR datapath.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state, nstate;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             accept, do_load, do_step;
  logic [WIDTH-1:0] step_nxt;
  logic             step_bit;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_q),
    .data    (data_out),
    .ser_in  (ser_in),
    .nxt     (step_nxt),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  // Every accepted operation spends at least one edge in RUN, so LOAD/HOLD
  // and zero-count ops all reach DONE at E+1.
  always_comb begin
    nstate  = state;
    accept  = 1'b0;
    do_load = 1'b0;
    do_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          nstate = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mode_q == MODE_LOAD) begin
          do_load = 1'b1;
          nstate  = ST_DONE;
        end else if (is_step_mode(mode_q) && cnt_q != '0) begin
          do_step = 1'b1;
          if (cnt_q == CNT_W'(1)) nstate = ST_DONE;
        end else begin
          nstate = ST_DONE;
        end
      end
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_HOLD;
      cnt_q    <= '0;
      data_q   <= '0;
      data_out <= '0;
      ser_out  <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        cnt_q  <= count;
        data_q <= data_in;
      end
      if (do_load) data_out <= data_q;
      if (do_step) begin
        data_out <= step_nxt;
        ser_out  <= step_bit;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed table-driven bench for univ_shift_reg (WIDTH=8, CNT_W=8), plus reset and held-start sequences.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] count = 8'd0;
  logic [7:0] data_in = 8'd0;
  logic       ser_in = 1'b0;
  logic [7:0] data_out;
  logic       ser_out, busy, done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .count(count),
    .data_in(data_in), .ser_in(ser_in), .data_out(data_out), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] cnt;
    logic [7:0] din;
    logic       sin;
    logic [7:0] exp_d;
    logic       exp_s;
    int         exp_lat;
  } vec_t;

  vec_t tbl[16];
  int   nv = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] m, input logic [7:0] c, input logic [7:0] d, input logic s,
                     input logic [7:0] ed, input logic es, input int el);
    tbl[nv].mode = m; tbl[nv].cnt = c; tbl[nv].din = d; tbl[nv].sin = s;
    tbl[nv].exp_d = ed; tbl[nv].exp_s = es; tbl[nv].exp_lat = el;
    nv++;
  endtask

  // Launch one op; after the accept edge the mode/count/data_in inputs are
  // scrambled so only latched values may influence the result.
  task automatic run_op(input logic [2:0] m, input logic [7:0] c, input logic [7:0] d,
                        input logic s, output int lat);
    @(negedge clk);
    start = 1'b1; mode = m; count = c; data_in = d; ser_in = s;
    @(negedge clk);
    start = 1'b0; mode = MODE_SHR; count = 8'd77; data_in = ~d;
    chk("busy_in_run", int'(busy), 1);
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses, first_lat, second_lat;
    logic [7:0] shl_exp[3];

    // table: each row starts from the previous row's result
    add(MODE_LOAD, 8'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1);
    add(MODE_LOAD, 8'd0,  8'h90, 1'b0, 8'h90, 1'b0, 1);
    add(MODE_ASR,  8'd2,  8'h00, 1'b1, 8'hE4, 1'b0, 2);
    add(MODE_SHR,  8'd3,  8'h00, 1'b0, 8'h1C, 1'b1, 3);
    add(MODE_HOLD, 8'd5,  8'hFF, 1'b0, 8'h1C, 1'b1, 1);
    add(MODE_SHL,  8'd0,  8'hFF, 1'b1, 8'h1C, 1'b1, 1);
    add(3'd7,      8'd4,  8'hFF, 1'b1, 8'h1C, 1'b1, 1);
    add(MODE_LOAD, 8'd0,  8'h01, 1'b0, 8'h01, 1'b1, 1);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    add(MODE_ROTR, 8'd9,  8'h00, 1'b0, 8'h80, 1'b1, 9);
    add(MODE_ROTL, 8'd3,  8'h00, 1'b1, 8'h04, 1'b0, 3);
`else
    add(MODE_ROTR, 8'd9,  8'h00, 1'b0, 8'h01, 1'b1, 1);
    add(MODE_ROTL, 8'd3,  8'h00, 1'b1, 8'h01, 1'b1, 1);
`endif
    add(MODE_SHR,  8'd10, 8'h00, 1'b1, 8'hFF, 1'b1, 10);
    add(MODE_LOAD, 8'd0,  8'h40, 1'b0, 8'h40, 1'b1, 1);
    add(MODE_ASR,  8'd3,  8'h00, 1'b0, 8'h08, 1'b0, 3);
    add(MODE_LOAD, 8'd0,  8'hC0, 1'b0, 8'hC0, 1'b0, 1);
    add(MODE_SHL,  8'd2,  8'h00, 1'b0, 8'h00, 1'b1, 2);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data_out), 0);
    chk("rst_ser",  int'(ser_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      run_op(tbl[i].mode, tbl[i].cnt, tbl[i].din, tbl[i].sin, lat);
      chk($sformatf("v%0d_lat", i),  lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_data", i), int'(data_out), int'(tbl[i].exp_d));
      chk($sformatf("v%0d_ser", i),  int'(ser_out), int'(tbl[i].exp_s));
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), int'(done), 0);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
    end

    // SHL 0x81 by 3 with ser_in=1, each intermediate step
    run_op(MODE_LOAD, 8'd0, 8'h81, 1'b0, lat);
    @(negedge clk);
    shl_exp[0] = 8'h03; shl_exp[1] = 8'h07; shl_exp[2] = 8'h0F;
    start = 1'b1; mode = MODE_SHL; count = 8'd3; ser_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("shl_step%0d", k + 1), int'(data_out), int'(shl_exp[k]));
    end
    chk("shl_ser", int'(ser_out), 0);
    chk("shl_done", int'(done), 1);
    @(negedge clk);
    chk("shl_done_off", int'(done), 0);

    // reset in the middle of a SHL count=5
    run_op(MODE_LOAD, 8'd0, 8'hFF, 1'b0, lat);
    @(negedge clk);
    start = 1'b1; mode = MODE_SHL; count = 8'd5; ser_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_step2", int'(data_out), 8'hFC);
    chk("mid_ser2", int'(ser_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_ser", int'(ser_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    // start on the first edge after reset release, count=0
    reset = 1'b0;
    start = 1'b1; mode = MODE_SHL; count = 8'd0; ser_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_busy", int'(busy), 1);
    if (done) pulses++;
    chk("no_done_after_rst", pulses, 0);
    @(negedge clk);
    chk("cnt0_done", int'(done), 1);
    chk("cnt0_data", int'(data_out), 0);
    @(negedge clk);

    // start held high: one op per IDLE entry (period N+2 = 6)
    run_op(MODE_LOAD, 8'd0, 8'h0F, 1'b0, lat);
    @(negedge clk);
    start = 1'b1; mode = MODE_SHL; count = 8'd4; ser_in = 1'b0;
    @(negedge clk);
    pulses = 0; first_lat = -1; second_lat = -1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first_lat < 0) first_lat = k;
        else if (second_lat < 0) second_lat = k;
        if (k == 4) chk("held_first_data", int'(data_out), 8'hF0);
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 2);
    chk("held_first", first_lat, 4);
    chk("held_second", second_lat, 10);
    repeat (8) @(negedge clk);
    chk("held_final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
